stopwatch_button_ctrl: RTL

Front-panel controller that drives the stopwatch counter core from three raw push-buttons. It synchronises and debounces each key and runs a run/pause/lap/clear state machine. It produces the core's active-low `start_stop`, `hold` and clear (`sw_reset_n`) levels, and returns status LEDs. It sits between the board keys and `StopwatchLogic`, in the same 100 Hz clock domain.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/button_debounce.sv | 53 +++++
 rtl/stopwatch_button_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch front-panel controller.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVF   = 3'd4,
    ST_CLEAR = 3'd5
  } sw_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned CLEAR_CYCLES_DEF    = 2;
  localparam logic        KEY_ACTIVE          = 1'b0;

endpackage

// File: rtl/button_debounce.sv
// Per-key synchroniser, debounce filter and one-shot press pulse.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Pulse fires on the same edge the level flips so the FSM acts one edge later.
  always_comb begin
    sync_d  = {sync_q[0], key_n};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync_q[1];
        press_d = (sync_q[1] == KEY_ACTIVE);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= ~KEY_ACTIVE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_button_ctrl.sv
// Run/pause/lap/clear controller between the board keys and the counter core.
module stopwatch_button_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CLEAR_CYCLES    = CLEAR_CYCLES_DEF
) (
  input  logic       CLK_100Hz,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_clear_n,
  input  logic       stopwatch_overflow,
  output logic       start_stop,
  output logic       hold,
  output logic       sw_reset_n,
  output logic       run_led,
  output logic       hold_led,
  output logic       ovf_led,
  output logic [2:0] state
);

  localparam int unsigned CCW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CCW-1:0] CLR_LAST = CCW'(CLEAR_CYCLES - 1);

  logic ev_start, ev_lap, ev_clear;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (CLK_100Hz),
    .reset (reset),
    .key_n (key_start_n),
    .press (ev_start)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (CLK_100Hz),
    .reset (reset),
    .key_n (key_lap_n),
    .press (ev_lap)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (CLK_100Hz),
    .reset (reset),
    .key_n (key_clear_n),
    .press (ev_clear)
  );

  sw_state_e      state_q, state_d;
  logic [CCW-1:0] clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    clr_d   = '0;
    case (state_q)
      ST_IDLE: if (ev_start) state_d = ST_RUN;
      ST_RUN, ST_LAP: begin
        if (stopwatch_overflow)  state_d = ST_OVF;
        else if (ev_start)       state_d = ST_PAUSE;
        else if (ev_lap)
          state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
      end
      ST_PAUSE: begin
        if (ev_clear)      state_d = ST_CLEAR;
        else if (ev_start) state_d = ST_RUN;
      end
      ST_OVF: if (ev_clear) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (clr_q == CLR_LAST) state_d = ST_IDLE;
        else                   clr_d   = clr_q + 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK_100Hz) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    run_led    = (state_q == ST_RUN) || (state_q == ST_LAP);
    hold_led   = (state_q == ST_LAP);
    ovf_led    = (state_q == ST_OVF);
    start_stop = ~run_led;
    hold       = ~hold_led;
    sw_reset_n = (state_q != ST_CLEAR);
    state      = state_q;
  end

endmodule
